dr_shift_serializer: RTL and testbench
======================================

// Module: dr_shift_serializer
// PURPOSE
//  Downstream consumer of the constant data-register source: captures its WIDTH-bit parallel
//  word (e.g. 32'd43981), shifts it out serially while shifting a new word in, then commits
//  the received word to a parallel update register. JTAG-style capture/shift/update data-reg
//  stage; all widths derive from $bits() of the shift register, never hard-coded literals.
// PARAMETERS
//  WIDTH      32            shift/data-register width, >= 1
//  LSB_FIRST  1             1: bit 0 shifted out first and sin_i enters at MSB; 0: mirrored
//  RESET_VAL  32'h0000ABCD  reset value of dr_q_o (truncated/zero-extended to WIDTH)
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst          in   1      asynchronous, active-high reset
//  par_i        in   WIDTH  parallel word from upstream source
//  capture_i    in   1      request to load par_i; accepted only when ready_o=1
//  ready_o      out  1      block idle, can accept capture
//  shift_en_i   in   1      advance one bit this cycle (SHIFT state only)
//  abort_i      in   1      abandon current shift, return to IDLE without update
//  sin_i        in   1      serial data in
//  sout_o       out  1      serial data out (registered)
//  dr_q_o       out  WIDTH  update register, holds last committed received word
//  done_o       out  1      one-cycle pulse: dr_q_o just updated
// BEHAVIOUR
//  Reset: state=IDLE, shreg=0, cnt=0, sout_o=0, ready_o=1, done_o=0, dr_q_o=RESET_VAL.
//  FSM IDLE -> SHIFT -> UPDATE -> IDLE.
//  IDLE: ready_o=1. capture_i=1 at edge T0 -> shreg<=par_i, cnt<=0, -> SHIFT.
//   sout_o shows the first-out bit of par_i from cycle after T0.
//  SHIFT: ready_o=0. Edge with shift_en_i=1: shreg shifts one position (sin_i enters the
//   vacated end), sout_o <= next out bit, cnt++. shift_en_i=0: full hold, no change.
//   Shift with cnt==WIDTH-1 is the last: dr_q_o <= post-shift shreg, done_o<=1, -> UPDATE.
//   capture_i is ignored outside IDLE (no queuing).
//  UPDATE: one cycle; done_o=1, ready_o=0; -> IDLE unconditionally; done_o cleared.
//  Latency with shift_en_i held high: capture at T0, shifts at T1..TWIDTH, done_o high the
//   cycle after TWIDTH, ready_o high again one cycle later.
//  abort_i (SHIFT or UPDATE): -> IDLE next edge, dr_q_o unchanged, done_o=0; abort wins
//   over a simultaneous last shift (no update); abort in IDLE has no effect.
//  cnt width $clog2(WIDTH)+1 bits; no wrap possible; WIDTH=1: one shift then UPDATE.
//  Reset asserted mid-operation: immediate return to reset values, no partial update.
//  Loopback (sin_i=sout_o): after WIDTH shifts shreg equals captured word.
// STRUCTURE
//  Package dr_pkg: typedef enum logic [1:0] {DR_IDLE, DR_SHIFT, DR_UPDATE} dr_state_e;
//   localparam DR_RESET_VAL default. Single sub-module dr_bit_counter
//   (clear, enable, terminal-count flag at WIDTH-1). Shift reg, FSM, update reg in top.
// TESTING
//  1. Reset, par_i=32'hABCD, capture, shift_en=1, sin_i=1 -> sout_o LSB-first
//     1,0,1,1,0,0,1,1,1,1,0,1,0,1,0,1 then 16x0; done_o one pulse; dr_q_o=32'hFFFF_FFFF.
//  2. Loopback sin_i=sout_o, par_i=32'hABCD -> after 32 shifts dr_q_o=32'h0000ABCD,
//     done_o exactly one cycle, ready_o returns 1 the following cycle.
//  3. shift_en_i toggled 1/0 every cycle -> 64 cycles of SHIFT, bit order identical to 1,
//     sout_o and cnt stable on stall cycles; capture_i pulses during SHIFT ignored.
//  4. abort_i on shift 20, and separately together with shift 32 -> IDLE, dr_q_o stays
//     32'h0000ABCD (reset value), done_o never asserts.
//  5. rst pulsed asynchronously mid-shift (between edges) -> outputs at reset values
//     immediately; a new capture completes normally.
//  6. WIDTH=1, par_i=1, sin_i=0 -> sout_o=1 one cycle, dr_q_o=0, done_o two cycles
//     after capture.

Source files
------------

// File: rtl/dr_shift_serializer_pkg.sv
// Shared types and defaults for the capture/shift/update data-register serializer.
package dr_pkg;

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_SHIFT,
    DR_UPDATE
  } dr_state_e;

  localparam logic [31:0] DR_RESET_VAL = 32'h0000ABCD;

endpackage

// File: rtl/dr_shift_serializer_if.sv
// Parallel-capture / serial-shift handshake bundle between the upstream source and the serializer.
interface dr_shift_serializer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] par_i;
  logic             capture_i;
  logic             ready_o;
  logic             shift_en_i;
  logic             abort_i;
  logic             sin_i;
  logic             sout_o;
  logic [WIDTH-1:0] dr_q_o;
  logic             done_o;

  modport master (
    output par_i, capture_i, shift_en_i, abort_i, sin_i,
    input  ready_o, sout_o, dr_q_o, done_o
  );

  modport slave (
    input  par_i, capture_i, shift_en_i, abort_i, sin_i,
    output ready_o, sout_o, dr_q_o, done_o
  );
endinterface

// File: rtl/dr_shift_serializer_bit_counter.sv
// Shift-position counter: clears on capture, advances per shift, flags the last bit position.
module dr_bit_counter #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == LAST);
endmodule

// File: rtl/dr_shift_serializer.sv
// JTAG-style data-register stage: capture a parallel word, shift it out serially while
// shifting a new word in, then commit the received word to the update register.
module dr_shift_serializer
  import dr_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter bit          LSB_FIRST = 1'b1,
  parameter logic [31:0] RESET_VAL = DR_RESET_VAL
) (
  input  logic                  clk,
  input  logic                  rst,
  dr_shift_serializer_if.slave  bus
);
  logic [WIDTH-1:0] shreg_q;

  localparam int SW = $bits(shreg_q);
  localparam logic [SW-1:0] UPD_RST = SW'(RESET_VAL);

  logic [SW-1:0] shreg_nxt;
  logic [SW-1:0] dr_q;
  logic          sout_q;
  dr_state_e     state_q, state_nxt;
  logic          do_capture, do_shift, do_commit;
  logic          cnt_clr, cnt_en, cnt_tc;

  // Incoming bit enters the end opposite to the one being shifted out.
  function automatic logic [SW-1:0] shift_word(input logic [SW-1:0] w, input logic s);
    if (LSB_FIRST) shift_word = SW'({s, w} >> 1);
    else           shift_word = SW'({w, s});
  endfunction

  function automatic logic out_bit(input logic [SW-1:0] w);
    out_bit = LSB_FIRST ? w[0] : w[SW-1];
  endfunction

  assign shreg_nxt = shift_word(shreg_q, bus.sin_i);

  dr_bit_counter #(.WIDTH(SW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DR_IDLE;
    else     state_q <= state_nxt;
  end

  // Abort takes priority over a shift, including the final one, so nothing is committed.
  always_comb begin
    state_nxt  = state_q;
    do_capture = 1'b0;
    do_shift   = 1'b0;
    do_commit  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_q)
      DR_IDLE: begin
        if (bus.capture_i) begin
          do_capture = 1'b1;
          cnt_clr    = 1'b1;
          state_nxt  = DR_SHIFT;
        end
      end
      DR_SHIFT: begin
        if (bus.abort_i) begin
          state_nxt = DR_IDLE;
        end else if (bus.shift_en_i) begin
          do_shift = 1'b1;
          cnt_en   = 1'b1;
          if (cnt_tc) begin
            do_commit = 1'b1;
            state_nxt = DR_UPDATE;
          end
        end
      end
      DR_UPDATE: state_nxt = DR_IDLE;
      default:   state_nxt = DR_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
      sout_q  <= 1'b0;
      dr_q    <= UPD_RST;
    end else begin
      if (do_capture) begin
        shreg_q <= bus.par_i;
        sout_q  <= out_bit(bus.par_i);
      end else if (do_shift) begin
        shreg_q <= shreg_nxt;
        sout_q  <= out_bit(shreg_nxt);
      end
      if (do_commit) dr_q <= shreg_nxt;
    end
  end

  assign bus.ready_o = (state_q == DR_IDLE);
  assign bus.done_o  = (state_q == DR_UPDATE);
  assign bus.sout_o  = sout_q;
  assign bus.dr_q_o  = dr_q;
endmodule

// File: tb/tb_dr_shift_serializer.sv
// Scoreboard bench: expected serial bits queued at capture, popped as the DUT shifts them out.
module tb_dr_shift_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  dr_shift_serializer_if #(.WIDTH(32)) bus  ();
  dr_shift_serializer_if #(.WIDTH(1))  bus1 ();

  dr_shift_serializer #(.WIDTH(32), .LSB_FIRST(1'b1), .RESET_VAL(32'h0000ABCD)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dr_shift_serializer #(.WIDTH(1), .LSB_FIRST(1'b1), .RESET_VAL(32'h0000ABCD)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [31:0] par, input bit loopback, input logic sin_val,
                      input bit stall, input int abort_at);
    logic [31:0] m_sh;
    logic [31:0] dr_before;
    logic        b, s;
    bit          aborted;
    aborted = 1'b0;
    chk("idle_ready", bus.ready_o, 1);
    dr_before     = bus.dr_q_o;
    bus.par_i     = par;
    bus.capture_i = 1'b1;
    cyc();
    bus.capture_i = 1'b0;
    m_sh = par;
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(par[i]);
    chk("busy", bus.ready_o, 0);
    for (int k = 1; k <= 32; k++) begin
      b = exp_q.pop_front();
      chk("sout", bus.sout_o, b);
      s = loopback ? bus.sout_o : sin_val;
      bus.sin_i      = s;
      bus.shift_en_i = 1'b1;
      bus.abort_i    = (k == abort_at);
      cyc();
      bus.shift_en_i = 1'b0;
      bus.abort_i    = 1'b0;
      if (k == abort_at) begin
        chk("abort_ready", bus.ready_o, 1);
        chk("abort_done", bus.done_o, 0);
        chk("abort_drq", bus.dr_q_o, dr_before);
        aborted = 1'b1;
        break;
      end
      m_sh = {s, m_sh[31:1]};
      if (k < 32) begin
        chk("no_done", bus.done_o, 0);
        if (stall) begin
          bus.capture_i = 1'b1;
          bus.par_i     = ~par;
          bus.sin_i     = ~s;
          cyc();
          bus.capture_i = 1'b0;
          chk("stall_sout", bus.sout_o, exp_q[0]);
          chk("stall_busy", bus.ready_o, 0);
          chk("stall_no_done", bus.done_o, 0);
        end
      end
    end
    if (!aborted) begin
      chk("done", bus.done_o, 1);
      chk("dr_q", bus.dr_q_o, m_sh);
      cyc();
      chk("done_clr", bus.done_o, 0);
      chk("ready_back", bus.ready_o, 1);
    end else begin
      cyc();
      chk("abort_no_done", bus.done_o, 0);
      chk("abort_drq_hold", bus.dr_q_o, dr_before);
    end
  endtask

  initial begin
    bus.par_i = '0;  bus.capture_i = 1'b0; bus.shift_en_i = 1'b0;
    bus.abort_i = 1'b0; bus.sin_i = 1'b0;
    bus1.par_i = '0; bus1.capture_i = 1'b0; bus1.shift_en_i = 1'b0;
    bus1.abort_i = 1'b0; bus1.sin_i = 1'b0;

    repeat (2) cyc();
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_done", bus.done_o, 0);
    chk("rst_sout", bus.sout_o, 0);
    chk("rst_drq", bus.dr_q_o, 32'h0000ABCD);
    chk("rst_drq_w1", bus1.dr_q_o, 1);
    rst = 1'b0;
    cyc();

    // Aborts: mid-word and together with the final shift.
    xfer(32'h0000ABCD, 1'b0, 1'b1, 1'b0, 20);
    chk("t4a_drq", bus.dr_q_o, 32'h0000ABCD);
    xfer(32'h0000ABCD, 1'b0, 1'b1, 1'b0, 32);
    chk("t4b_drq", bus.dr_q_o, 32'h0000ABCD);

    xfer(32'h0000ABCD, 1'b0, 1'b1, 1'b0, 0);
    chk("t1_drq", bus.dr_q_o, 32'hFFFF_FFFF);

    xfer(32'h0000ABCD, 1'b0, 1'b1, 1'b1, 0);
    chk("t3_drq", bus.dr_q_o, 32'hFFFF_FFFF);

    xfer(32'h0000ABCD, 1'b1, 1'b0, 1'b0, 0);
    chk("t2_drq", bus.dr_q_o, 32'h0000ABCD);

    xfer($urandom, 1'b0, 1'b0, 1'b0, 0);
    chk("zero_drq", bus.dr_q_o, 32'h0);

    // Asynchronous reset between edges while shifting; bit 10 of the word is 1.
    bus.par_i     = 32'h5A5A_1634;
    bus.capture_i = 1'b1;
    cyc();
    bus.capture_i  = 1'b0;
    bus.sin_i      = 1'b1;
    bus.shift_en_i = 1'b1;
    repeat (10) cyc();
    bus.shift_en_i = 1'b0;
    chk("pre_rst_sout", bus.sout_o, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", bus.ready_o, 1);
    chk("arst_sout", bus.sout_o, 0);
    chk("arst_done", bus.done_o, 0);
    chk("arst_drq", bus.dr_q_o, 32'h0000ABCD);
    #1 rst = 1'b0;
    cyc();
    xfer(32'h0F0F_3C3C, 1'b0, 1'b0, 1'b0, 0);

    // Single-bit register.
    chk("w1_ready", bus1.ready_o, 1);
    bus1.par_i      = 1'b1;
    bus1.sin_i      = 1'b0;
    bus1.shift_en_i = 1'b1;
    bus1.capture_i  = 1'b1;
    cyc();
    bus1.capture_i = 1'b0;
    chk("w1_sout", bus1.sout_o, 1);
    chk("w1_no_done", bus1.done_o, 0);
    cyc();
    chk("w1_done", bus1.done_o, 1);
    chk("w1_drq", bus1.dr_q_o, 0);
    chk("w1_sout_after", bus1.sout_o, 0);
    bus1.shift_en_i = 1'b0;
    cyc();
    chk("w1_done_clr", bus1.done_o, 0);
    chk("w1_ready_back", bus1.ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
